// File: rtl/dac_stream_pkg.sv
// Shared stream-width definitions for the DAC/ADC width converters.
package dac_stream_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_t;

  localparam string ORDER_LOW_FIRST  = "LOW_FIRST";
  localparam string ORDER_HIGH_FIRST = "HIGH_FIRST";

  // Output beat width in bits.
  function automatic int ow_of(input int nsamp, input int sampbits);
    return nsamp * sampbits;
  endfunction

  // Input word width in bits (two output beats).
  function automatic int iw_of(input int nsamp, input int sampbits);
    return 2 * nsamp * sampbits;
  endfunction

endpackage

// File: rtl/dac_split_x2.sv
// AXI4-Stream width halver: one 2*NSAMP-sample word in, two NSAMP-sample beats out.
module dac_split_x2
  import dac_stream_pkg::*;
#(
  parameter int    NSAMP    = 8,
  parameter int    SAMPBITS = 16,
  parameter string ORDER    = ORDER_LOW_FIRST,
  localparam int   OW       = ow_of(NSAMP, SAMPBITS),
  localparam int   IW       = iw_of(NSAMP, SAMPBITS)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [IW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [OW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tuser,
  output logic [31:0]   words_o
);

  localparam bit HI_FIRST = (ORDER == ORDER_HIGH_FIRST);

  state_t        state_q, state_d;
  logic          run_q;
  logic [IW-1:0] hold_q, hold_d;
  logic [31:0]   words_q, words_d;
  logic          s_hs, m_hs;
  logic          sel_hi;

  // Input is only taken when nothing is held, or when the last half leaves this cycle.
  assign s_axis_tready = run_q && ((state_q == ST_EMPTY) ||
                                   ((state_q == ST_SECOND) && m_axis_tready));
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = (state_q != ST_EMPTY);
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign m_axis_tuser  = (state_q == ST_SECOND);
  // Pick the half being presented; HIGH_FIRST just inverts the selection.
  assign sel_hi        = (state_q == ST_SECOND) ^ HI_FIRST;
  assign m_axis_tdata  = sel_hi ? hold_q[IW-1:OW] : hold_q[OW-1:0];
  assign words_o       = words_q;

  // Run flag: holds off input for the first cycle after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // State, hold register and word counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      words_q <= words_d;
    end
  end

  // Next-state: a second-half handshake can coincide with a new accept (no bubble).
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    words_d = words_q;
    case (state_q)
      ST_EMPTY: begin
        if (s_hs) begin
          hold_d  = s_axis_tdata;
          state_d = ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (m_hs) state_d = ST_SECOND;
      end
      ST_SECOND: begin
        if (m_hs) begin
          words_d = words_q + 32'd1;
          if (s_hs) begin
            hold_d  = s_axis_tdata;
            state_d = ST_FIRST;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

endmodule
